uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver paired with the existing `uart` transmitter on the 50 MHz domain. It recovers 8N1 frames (LSB first) from the asynchronous `rx` line using 16x oversampling from a phase-accumulator baud tick. It presents each byte with a one-cycle `valid` strobe, and flags frames whose stop bit is low.

## Interface
- `ACC_WIDTH`, 16: phase-accumulator width.
- `BAUD_INC`, 2416: accumulator increment per `clock50` cycle.
  - With `ACC_WIDTH` = 16 this gives 50e6·2416/65536 ≈ 1.8433 MHz, i.e. 16 × 115200 baud.
- `clock50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle high.
- `data`  out  8  last correctly received byte; updated only with `valid`.
- `valid`  out  1  one-cycle strobe: `data` was updated this cycle.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1.
- **Baud tick:** the accumulator adds `BAUD_INC` every `clock50` cycle. `tick` = carry-out, high for exactly one cycle. The accumulator free-runs and is never cleared except by reset.
- **Oversample counter:** `os_cnt` is 4 bits. It is cleared on every state entry and increments on `tick`.
- **IDLE:**
  - On any cycle with `rx_s` = 0, go to START. Not gated by `tick`.
- **START:**
  - On `tick` with `os_cnt` = 7 (mid start bit), sample `rx_s`.
  - If 1: false start, return to IDLE.
  - If 0: clear the bit counter and go to DATA.
- **DATA:**
  - On `tick` with `os_cnt` = 15, right-shift `rx_s` into the shift register at bit 7. The first bit received ends at bit 0.
  - The bit counter increments on each sample. After the 8th sample, go to STOP.
- **STOP:** on `tick` with `os_cnt` = 15, sample `rx_s`.
  - If 1: load `data` from the shift register, pulse `valid`, go to IDLE.
  - If 0: pulse `frame_err`, leave `data` unchanged, go to WAIT_IDLE.
- **WAIT_IDLE (break/line fault):**
  - Go to IDLE on the first cycle with `rx_s` = 1.
  - No new frame is detected until then.
- `valid` and `frame_err` are never high in the same cycle.
- Unreachable state encodings go to IDLE.

## Timing
- **Reset values:**
  - `data` = 0x00, `valid` = 0, `frame_err` = 0, `busy` = 0.
  - State = IDLE, accumulator = 0, `os_cnt` = 0, synchronizer = 11.
- **Reset mid-frame:** all outputs take their reset values immediately (asynchronous). The partial byte is discarded.
- **Detection latency:** a falling edge on `rx` reaches `rx_s` after 2 `clock50` edges. START is entered on the next edge.
- **Sample points:** mid start bit is 8 ticks after START entry; each following sample is 16 ticks later. Detection jitter is ≤ 1 tick + 3 clocks (< 1/16 bit + 60 ns).
- **`valid` / `frame_err` timing:** asserted in the `clock50` cycle after the stop-bit sample tick, i.e. ≈ 9.5 bit times after the start-bit falling edge. Each is high for 1 cycle.
- **Back-to-back frames:** the receiver is in IDLE by mid stop bit, so a start bit directly after a 1-bit stop is caught.
- **Tolerance:** at least ±3 % baud mismatch.

## Structure
- **Package `uart_pkg`:**
  - State typedef: IDLE, START, DATA, STOP, WAIT_IDLE.
  - `ACC_WIDTH` = 16.
  - `TX_BAUD_INC` = 151 (1× tick for the transmitter).
  - `RX_BAUD_INC` = 2416.
- **Sub-module `uart_baud_tick`:**
  - Parameters `ACC_WIDTH`, `INC`; ports `clock50`, `reset`, `tick`.
  - Implements the phase accumulator and carry-out strobe.
  - Intended to be shared with the transmitter later.

## Test plan
- **Clean byte:** drive 0x40 at 115200 8N1 → one `valid` pulse with `data` = 0x40, `frame_err` = 0, `busy` back to 0 ≈ 82 µs after the start edge.
- **Glitch:** 3 µs low pulse on `rx` (< half bit of 4.34 µs) → `busy` high ≈ 4.3 µs then 0; no `valid`, no `frame_err`.
- **Bad stop bit:** after 0x40, send 0x55 with stop bit 0 and hold low 200 µs → one `frame_err` pulse, `data` stays 0x40, `busy` stays high until `rx` returns to 1.
- **Back-to-back:** 0x00, 0xFF, 0xA5 with single stop bits → three `valid` pulses with `data` 0x00, 0xFF, 0xA5 in order.
- **Reset mid-frame:** assert `reset` during data bit 4 of 0x3C → outputs clear asynchronously. After release and ≥ 1 bit of idle, 0xA5 is received correctly.
- **Baud skew:** 0x96 sent at 118656 baud (+3 %) and at 111744 baud (−3 %) → `data` = 0x96 with `valid`, `frame_err` = 0, in both cases.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud-generator constants
// for the 50 MHz clock domain.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_t;

    localparam int ACC_WIDTH   = 16;
    // 1x bit-rate tick for the transmitter (50e6 * 151 / 65536 ~= 115200 Hz)
    localparam int TX_BAUD_INC = 151;
    // 16x oversampling tick for the receiver (~= 1.8433 MHz)
    localparam int RX_BAUD_INC = 2416;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte/strobes/status out.
`timescale 1ns/1ps
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    // master: the receiver itself
    modport master (input rx, output data, valid, frame_err, busy);
    // slave: whoever drives the line and consumes the bytes
    modport slave  (output rx, input data, valid, frame_err, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Phase-accumulator baud generator; tick is the carry-out of the
// accumulator, one clock wide. Free-running, cleared only by reset.
`timescale 1ns/1ps
module uart_baud_tick #(
    parameter int ACC_WIDTH = 16,
    parameter int INC       = 2416
) (
    input  logic clock50,
    input  logic reset,
    output logic tick
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;

    assign sum = {1'b0, acc} + (ACC_WIDTH+1)'(INC);

    // Accumulate every cycle and register the carry as the tick strobe
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            tick <= 1'b0;
        end else begin
            acc  <= sum[ACC_WIDTH-1:0];
            tick <= sum[ACC_WIDTH];
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. Emits each good byte with a
// one-cycle valid strobe and flags a low stop bit with frame_err.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int ACC_WIDTH = uart_pkg::ACC_WIDTH,
    parameter int BAUD_INC  = RX_BAUD_INC
) (
    input  logic      clock50,
    input  logic      reset,
    uart_rx_if.master bus
);

    logic        rx_meta;
    logic        rx_s;
    logic        tick;
    uart_state_t state;
    logic [3:0]  os_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        ferr_q;
    logic        busy_q;

    uart_baud_tick #(
        .ACC_WIDTH (ACC_WIDTH),
        .INC       (BAUD_INC)
    ) u_tick (
        .clock50 (clock50),
        .reset   (reset),
        .tick    (tick)
    );

    // Two-flop synchronizer for the asynchronous line, idling high
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: os_cnt is zeroed on every state entry so each sample
    // point is a fixed number of ticks after entry
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                IDLE: begin
                    os_cnt <= '0;
                    if (!rx_s) begin
                        state  <= START;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (os_cnt == 4'd7) begin
                            os_cnt <= '0;
                            if (rx_s) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                bit_cnt <= '0;
                                state   <= DATA;
                            end
                        end else begin
                            os_cnt <= os_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        // 15 -> 0 wrap lines up the next bit centre
                        os_cnt <= os_cnt + 4'd1;
                        if (os_cnt == 4'd15) begin
                            shreg   <= {rx_s, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state  <= STOP;
                                os_cnt <= '0;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        os_cnt <= os_cnt + 4'd1;
                        if (os_cnt == 4'd15) begin
                            os_cnt <= '0;
                            if (rx_s) begin
                                data_q  <= shreg;
                                valid_q <= 1'b1;
                                state   <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                ferr_q <= 1'b1;
                                state  <= WAIT_IDLE;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        os_cnt <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    os_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are bit-banged on rx, the expected
// outcome of each frame is queued, and every valid/frame_err strobe pops
// and checks one entry.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam real BIT_NS = 1.0e9 / 115200.0;

    typedef struct packed {
        logic       is_ferr;
        logic [7:0] data;
    } sb_item_t;

    logic clock50;
    logic reset;
    int   vectors;
    int   miscompares;
    sb_item_t sb[$];

    uart_rx_if bus ();

    uart_rx dut (
        .clock50 (clock50),
        .reset   (reset),
        .bus     (bus.master)
    );

    initial clock50 = 1'b0;
    always #10 clock50 = ~clock50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
        bus.rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            #(bit_ns);
        end
        bus.rx = stop_bit;
        #(bit_ns);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        sb.push_back('{is_ferr: 1'b0, data: b});
    endtask

    task automatic expect_ferr(input logic [7:0] held);
        sb.push_back('{is_ferr: 1'b1, data: held});
    endtask

    // Monitor: each output strobe consumes one scoreboard entry
    always @(negedge clock50) begin
        if (!reset && (bus.valid || bus.frame_err)) begin
            sb_item_t it;
            if (bus.valid && bus.frame_err)
                check("valid_and_ferr", 32'(bus.frame_err), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, bus.frame_err, bus.valid}, 32'd0);
            end else begin
                it = sb.pop_front();
                check("strobe_kind", 32'(bus.frame_err), 32'(it.is_ferr));
                check("data", 32'(bus.data), 32'(it.data));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.rx      = 1'b1;
        reset       = 1'b1;
        repeat (5) @(posedge clock50);
        @(negedge clock50);
        check("rst_data", 32'(bus.data), 32'h00);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        #(BIT_NS);

        // Clean byte
        expect_byte(8'h40);
        send_frame(8'h40, 1'b1, BIT_NS);
        check("clean_busy", 32'(bus.busy), 32'd0);
        #(BIT_NS);

        // Glitch shorter than half a bit
        bus.rx = 1'b0;
        #3000;
        bus.rx = 1'b1;
        check("glitch_busy_hi", 32'(bus.busy), 32'd1);
        #3000;
        check("glitch_busy_lo", 32'(bus.busy), 32'd0);
        #(BIT_NS);

        // Bad stop bit, line held low as a break
        expect_ferr(8'h40);
        send_frame(8'h55, 1'b0, BIT_NS);
        #200000;
        check("break_busy", 32'(bus.busy), 32'd1);
        check("break_data", 32'(bus.data), 32'h40);
        bus.rx = 1'b1;
        #200;
        check("break_recover", 32'(bus.busy), 32'd0);
        #(BIT_NS);

        // Back-to-back frames with single stop bits
        expect_byte(8'h00);
        expect_byte(8'hFF);
        expect_byte(8'hA5);
        send_frame(8'h00, 1'b1, BIT_NS);
        send_frame(8'hFF, 1'b1, BIT_NS);
        send_frame(8'hA5, 1'b1, BIT_NS);
        #(BIT_NS);
        check("b2b_pending", 32'(sb.size()), 32'd0);

        // Reset in the middle of data bit 4 of 0x3C
        bus.rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            bus.rx = (8'h3C >> i) & 8'h01;
            #(BIT_NS);
        end
        bus.rx = 1'b1;
        #(BIT_NS / 2.0);
        check("midrst_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_data", 32'(bus.data), 32'h00);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.valid), 32'd0);
        check("midrst_ferr", 32'(bus.frame_err), 32'd0);
        repeat (4) @(posedge clock50);
        @(negedge clock50);
        reset = 1'b0;
        #(BIT_NS);
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1, BIT_NS);
        #(BIT_NS);

        // Baud skew +3 % and -3 %
        expect_byte(8'h96);
        send_frame(8'h96, 1'b1, 1.0e9 / 118656.0);
        #(BIT_NS);
        expect_byte(8'h96);
        send_frame(8'h96, 1'b1, 1.0e9 / 111744.0);
        #(BIT_NS);
        check("skew_busy", 32'(bus.busy), 32'd0);

        check("pending_at_end", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
